// File: rtl/mpi_noc_pkg.sv
// Shared NoC flit definitions used by the packet buffer and the MPI endpoint.
package mpi_noc_pkg;

    localparam int NOC_FLIT_WIDTH_DEFAULT = 32;

    // One stored flit: payload plus its end-of-packet marker.
    typedef struct packed {
        logic                              last;
        logic [NOC_FLIT_WIDTH_DEFAULT-1:0] data;
    } flit_t;

endpackage

// File: rtl/mpi_noc_buffer_ram.sv
// Flit storage: one synchronous write port, one asynchronous read port.
// Contents are not reset; validity is tracked by the pointers in the top.
module mpi_noc_buffer_ram #(
    parameter int W     = 32,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [W:0]               wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [W:0]               rdata
);

    logic [W:0] mem [DEPTH];

    // Write the accepted flit (bit W is the last marker).
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/mpi_noc_packet_buffer.sv
// Store-and-forward packet buffer between a NoC router port and the MPI
// endpoint. A packet is released only after its last flit is stored, unless
// the buffer fills with no complete packet inside, in which case it falls
// back to cut-through so an over-long packet cannot deadlock the link.
//
// Handshake: a transfer happens on a rising clk edge when valid and ready
// are both high; valid never waits for ready, ready never depends on valid,
// and once valid is up the payload holds until the transfer.
module mpi_noc_packet_buffer
    import mpi_noc_pkg::*;
#(
    parameter int NOC_FLIT_WIDTH = NOC_FLIT_WIDTH_DEFAULT,
    parameter int DEPTH          = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NOC_FLIT_WIDTH-1:0]  in_flit,
    input  logic                       in_last,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [NOC_FLIT_WIDTH-1:0]  out_flit,
    output logic                       out_last,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] packet_count,
    output logic                       cut_through
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    ct_q, ct_d;
    logic                    empty, full, write, read;
    logic [NOC_FLIT_WIDTH:0] rd_word;

    mpi_noc_buffer_ram #(
        .W     (NOC_FLIT_WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (write),
        .waddr (wr_ptr_q[AW-1:0]),
        .wdata ({in_last, in_flit}),
        .raddr (rd_ptr_q[AW-1:0]),
        .rdata (rd_word)
    );

    // Occupancy, handshakes and the gated output flit.
    always_comb begin
        empty     = (wr_ptr_q == rd_ptr_q);
        full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        in_ready  = !full;
        out_valid = !empty && ((cnt_q != '0) || ct_q);
        write     = in_valid && in_ready;
        read      = out_valid && out_ready;
        out_flit  = out_valid ? rd_word[NOC_FLIT_WIDTH-1:0] : '0;
        out_last  = out_valid ? rd_word[NOC_FLIT_WIDTH] : 1'b0;
    end

    // Next pointers, packet count and cut-through flag.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        ct_d     = ct_q;
        if (write) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (read) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if ((write && in_last) && !(read && out_last)) begin
            cnt_d = cnt_q + CW'(1);
        end else if (!(write && in_last) && (read && out_last)) begin
            cnt_d = cnt_q - CW'(1);
        end
        // A full buffer with no complete packet can only drain by streaming.
        if (full && (cnt_q == '0)) begin
            ct_d = 1'b1;
        end
        // Leaving cut-through takes priority over entering it.
        if (read && out_last) begin
            ct_d = 1'b0;
        end
    end

    // State registers; reset drops any stored or partial packet.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ct_q     <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            ct_q     <= ct_d;
        end
    end

    assign packet_count = cnt_q;
    assign cut_through  = ct_q;

endmodule

// File: tb/tb_mpi_noc_packet_buffer.sv
// Directed bench for mpi_noc_packet_buffer: a vector table for reset and a
// single short packet, hand-written sequences for the multi-cycle corners,
// and a running scoreboard plus output-hold check on every driven cycle.
module tb_mpi_noc_packet_buffer;

  localparam int W  = 32;
  localparam int D  = 16;
  localparam int CW = $clog2(D + 1);

  logic          clk;
  logic          rst;
  logic [W-1:0]  in_flit;
  logic          in_last;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  out_flit;
  logic          out_last;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] packet_count;
  logic          cut_through;

  mpi_noc_packet_buffer #(.NOC_FLIT_WIDTH(W), .DEPTH(D)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_flit      (in_flit),
    .in_last      (in_last),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .out_flit     (out_flit),
    .out_last     (out_last),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .packet_count (packet_count),
    .cut_through  (cut_through)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- scoreboard state ----------------
  int           n_vec;
  int           n_fail;
  logic [W:0]   exp_q[$];
  logic         prev_hold;
  logic [W:0]   prev_word;
  logic         last_wr;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic e_ir, input logic e_ov,
                         input logic [W-1:0] e_f, input logic e_l,
                         input logic [CW-1:0] e_cnt, input logic e_ct);
    chk({tag, ".in_ready"},     64'(in_ready),     64'(e_ir));
    chk({tag, ".out_valid"},    64'(out_valid),    64'(e_ov));
    chk({tag, ".out_flit"},     64'(out_flit),     64'(e_f));
    chk({tag, ".out_last"},     64'(out_last),     64'(e_l));
    chk({tag, ".packet_count"}, 64'(packet_count), 64'(e_cnt));
    chk({tag, ".cut_through"},  64'(cut_through),  64'(e_ct));
  endtask

  // Per-cycle observation: hold rule, then reads against the queue, then writes.
  task automatic observe();
    logic wr, rd;
    logic [W:0] w;
    wr = in_valid && in_ready;
    rd = out_valid && out_ready;
    if (prev_hold) begin
      chk("hold.out_valid", 64'(out_valid), 64'(1));
      chk("hold.out_word", 64'({out_last, out_flit}), 64'(prev_word));
    end
    if (rd) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL sb_underflow: got read of %0h expected no read", {out_last, out_flit});
      end else begin
        w = exp_q.pop_front();
        chk("sb.word", 64'({out_last, out_flit}), 64'(w));
      end
    end
    if (wr) exp_q.push_back({in_last, in_flit});
    prev_hold = out_valid && !out_ready;
    prev_word = {out_last, out_flit};
    last_wr   = wr;
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic v, input logic [W-1:0] f, input logic l, input logic ordy);
    @(negedge clk);
    in_valid  = v;
    in_flit   = f;
    in_last   = l;
    out_ready = ordy;
    #1;
    observe();
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 64) begin
      step(1'b0, '0, 1'b0, 1'b1);
      n++;
    end
    if (exp_q.size() != 0) begin
      n_vec++;
      n_fail++;
      $display("FAIL %s.drain_timeout: got %0d flits left expected 0", tag, exp_q.size());
    end
    step(1'b0, '0, 1'b0, 1'b1);
    chk({tag, ".end_valid"}, 64'(out_valid), 64'(0));
    chk({tag, ".end_count"}, 64'(packet_count), 64'(0));
    chk({tag, ".end_ct"},    64'(cut_through), 64'(0));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic          v;
    logic [W-1:0]  f;
    logic          l;
    logic          ordy;
    logic          e_ir;
    logic          e_ov;
    logic [W-1:0]  e_f;
    logic          e_l;
    logic [CW-1:0] e_cnt;
    logic          e_ct;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int idx;
    int n;
    n_vec     = 0;
    n_fail    = 0;
    prev_hold = 1'b0;
    prev_word = '0;
    last_wr   = 1'b0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_flit   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;

    // reset, then a 3-flit packet with the sink always ready
    tbl[0] = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 5'd0, 1'b0};
    tbl[1] = '{1'b1, 32'hA1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 5'd0, 1'b0};
    tbl[2] = '{1'b1, 32'hA2, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 5'd0, 1'b0};
    tbl[3] = '{1'b1, 32'hA3, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 5'd0, 1'b0};
    tbl[4] = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 1'b1, 32'hA1, 1'b0, 5'd1, 1'b0};
    tbl[5] = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 1'b1, 32'hA2, 1'b0, 5'd1, 1'b0};
    tbl[6] = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 1'b1, 32'hA3, 1'b1, 5'd1, 1'b0};
    tbl[7] = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 5'd0, 1'b0};

    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      step(tbl[i].v, tbl[i].f, tbl[i].l, tbl[i].ordy);
      chk_all($sformatf("vec%0d", i), tbl[i].e_ir, tbl[i].e_ov, tbl[i].e_f,
              tbl[i].e_l, tbl[i].e_cnt, tbl[i].e_ct);
    end

    // four 4-flit packets fill the buffer, extra flit stalls
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 32'h100 + 32'(i), (i % 4) == 3, 1'b0);
    end
    step(1'b1, 32'h200, 1'b1, 1'b0);
    chk_all("full4", 1'b0, 1'b1, 32'h100, 1'b0, 5'd4, 1'b0);
    idx = 0;
    for (int k = 0; k < 5; k++) begin
      step(idx == 0, 32'h200, 1'b1, 1'b1);
      if (k == 0) chk("full4.ready_k0", 64'(in_ready), 64'(0));
      if (k == 1) chk("full4.ready_k1", 64'(in_ready), 64'(1));
      if (last_wr) idx = 1;
    end
    drain("full4");

    // 20-flit packet forces cut-through
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 32'h300 + 32'(i), 1'b0, 1'b0);
    end
    step(1'b0, '0, 1'b0, 1'b0);
    chk("long.full_ready", 64'(in_ready), 64'(0));
    step(1'b0, '0, 1'b0, 1'b0);
    chk_all("long.ct", 1'b0, 1'b1, 32'h300, 1'b0, 5'd0, 1'b1);
    idx = 16;
    n = 0;
    while ((idx < 20 || exp_q.size() != 0) && n < 80) begin
      step(idx < 20, 32'h300 + 32'(idx), idx == 19, 1'b1);
      if (last_wr) idx++;
      n++;
    end
    if (idx < 20 || exp_q.size() != 0) begin
      n_vec++;
      n_fail++;
      $display("FAIL long.timeout: got %0d written %0d queued expected 20 written 0 queued", idx, exp_q.size());
    end
    drain("long");

    // last flit of B written while last flit of A is read
    step(1'b1, 32'h401, 1'b0, 1'b0);
    step(1'b1, 32'h402, 1'b1, 1'b0);
    step(1'b1, 32'h411, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1);
    chk_all("simul.pre", 1'b1, 1'b1, 32'h401, 1'b0, 5'd1, 1'b0);
    step(1'b1, 32'h412, 1'b1, 1'b1);
    chk_all("simul.same", 1'b1, 1'b1, 32'h402, 1'b1, 5'd1, 1'b0);
    step(1'b1, 32'h421, 1'b1, 1'b1);
    chk_all("simul.post", 1'b1, 1'b1, 32'h411, 1'b0, 5'd1, 1'b0);
    drain("simul");

    // asynchronous reset with one complete and one partial packet stored
    step(1'b1, 32'h501, 1'b1, 1'b0);
    step(1'b1, 32'h511, 1'b0, 1'b0);
    step(1'b1, 32'h512, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    chk_all("rst.pre", 1'b1, 1'b1, 32'h501, 1'b1, 5'd1, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_all("rst.async", 1'b1, 1'b0, 32'h0, 1'b0, 5'd0, 1'b0);
    exp_q.delete();
    prev_hold = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 32'h55, 1'b1, 1'b1);
    chk_all("rst.new_in", 1'b1, 1'b0, 32'h0, 1'b0, 5'd0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1);
    chk_all("rst.new_out", 1'b1, 1'b1, 32'h55, 1'b1, 5'd1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1);
    chk_all("rst.idle", 1'b1, 1'b0, 32'h0, 1'b0, 5'd0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
